// File: rtl/rob_multi_cdb.sv
// Reorder buffer: in-order commit, multi-CDB writeback, operand forwarding,
// mispredict detection at commit with full flush.
module rob_multi_cdb #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int XLEN    = 32,
    parameter int NUM_CDB = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     disp_valid,
    input  logic [4:0]               disp_rd,
    input  logic                     disp_is_store,
    input  logic                     disp_is_br,
    input  logic                     disp_pred_taken,
    input  logic [XLEN-1:0]          disp_pred_target,
    input  logic [XLEN-1:0]          disp_fallthru,
    input  logic                     disp_done,
    input  logic [XLEN-1:0]          disp_value,
    output logic [IDX_W-1:0]         disp_tag,
    output logic                     full,
    input  logic [IDX_W-1:0]         q1_tag,
    input  logic [IDX_W-1:0]         q2_tag,
    output logic                     q1_ready,
    output logic                     q2_ready,
    output logic [XLEN-1:0]          q1_val,
    output logic [XLEN-1:0]          q2_val,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*IDX_W-1:0] cdb_tag,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_value,
    input  logic [NUM_CDB-1:0]       cdb_taken,
    output logic                     cm_valid,
    output logic [4:0]               cm_rd,
    output logic [XLEN-1:0]          cm_value,
    output logic [IDX_W-1:0]         cm_tag,
    output logic                     cm_store,
    output logic                     flush,
    output logic [XLEN-1:0]          flush_pc
);

    logic [ENTRIES-1:0] vld_q, rdy_q, br_q, st_q, pt_q, at_q;
    logic [4:0]         rd_q  [ENTRIES];
    logic [XLEN-1:0]    val_q [ENTRIES];
    logic [XLEN-1:0]    ptg_q [ENTRIES];
    logic [XLEN-1:0]    ft_q  [ENTRIES];
    logic [XLEN-1:0]    atg_q [ENTRIES];

    logic [IDX_W-1:0]   head, tail;
    logic [IDX_W:0]     count;

    logic [ENTRIES-1:0] hit, hit_tk, wb;
    logic [XLEN-1:0]    hit_val [ENTRIES];
    logic               commit, mispredict, flush_now, disp_acc;

    // Descending scan so the lowest channel index wins on a shared tag
    always_comb begin
        for (int e = 0; e < ENTRIES; e++) begin
            hit[e]     = 1'b0;
            hit_tk[e]  = 1'b0;
            hit_val[e] = '0;
            for (int k = NUM_CDB - 1; k >= 0; k--) begin
                if (cdb_valid[k] && cdb_tag[k*IDX_W +: IDX_W] == IDX_W'(e)) begin
                    hit[e]     = 1'b1;
                    hit_tk[e]  = cdb_taken[k];
                    hit_val[e] = cdb_value[k*XLEN +: XLEN];
                end
            end
        end
        wb = vld_q & ~rdy_q & hit;
    end

    assign full       = count == (IDX_W+1)'(ENTRIES);
    assign disp_tag   = tail;
    assign commit     = (count != '0) && rdy_q[head];
    assign mispredict = br_q[head] &&
                        ((at_q[head] != pt_q[head]) ||
                         (at_q[head] && atg_q[head] != ptg_q[head]));
    assign flush_now  = commit && mispredict;
    assign disp_acc   = rdy && disp_valid && !full && !flush_now;

    function automatic logic [XLEN:0] query(input logic [IDX_W-1:0] t);
        if (!vld_q[t])
            return '0;
        if (rdy_q[t])
            return {1'b1, val_q[t]};
        if (hit[t])
            return {1'b1, br_q[t] ? val_q[t] : hit_val[t]};
        return '0;
    endfunction

    assign {q1_ready, q1_val} = query(q1_tag);
    assign {q2_ready, q2_val} = query(q2_tag);

    always_ff @(posedge clk) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            vld_q    <= '0;
            rdy_q    <= '0;
            cm_valid <= 1'b0;
            cm_rd    <= '0;
            cm_value <= '0;
            cm_tag   <= '0;
            cm_store <= 1'b0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else if (!rdy) begin
            cm_valid <= 1'b0;
            flush    <= 1'b0;
        end else begin
            cm_valid <= commit;
            flush    <= flush_now;
            if (commit) begin
                cm_rd    <= st_q[head] ? 5'd0 : rd_q[head];
                cm_value <= val_q[head];
                cm_tag   <= head;
                cm_store <= st_q[head];
            end
            if (flush_now) begin
                flush_pc <= at_q[head] ? atg_q[head] : ft_q[head];
                vld_q    <= '0;
                rdy_q    <= '0;
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                for (int e = 0; e < ENTRIES; e++)
                    if (wb[e])
                        rdy_q[e] <= 1'b1;
                if (commit) begin
                    vld_q[head] <= 1'b0;
                    rdy_q[head] <= 1'b0;
                    head        <= head + 1'b1;
                end
                if (disp_acc) begin
                    vld_q[tail] <= 1'b1;
                    rdy_q[tail] <= disp_done;
                    tail        <= tail + 1'b1;
                end
                count <= count + (IDX_W+1)'(disp_acc) - (IDX_W+1)'(commit);
            end
        end
    end

    // Payload storage; liveness is tracked solely by vld_q/rdy_q
    always_ff @(posedge clk) begin
        if (rdy && !flush_now) begin
            for (int e = 0; e < ENTRIES; e++) begin
                if (wb[e]) begin
                    if (br_q[e]) begin
                        at_q[e]  <= hit_tk[e];
                        atg_q[e] <= hit_val[e];
                    end else begin
                        val_q[e] <= hit_val[e];
                    end
                end
            end
            if (disp_acc) begin
                rd_q[tail]  <= disp_rd;
                st_q[tail]  <= disp_is_store;
                br_q[tail]  <= disp_is_br;
                pt_q[tail]  <= disp_pred_taken;
                ptg_q[tail] <= disp_pred_target;
                ft_q[tail]  <= disp_fallthru;
                val_q[tail] <= disp_value;
                at_q[tail]  <= disp_pred_taken;
                atg_q[tail] <= disp_pred_target;
            end
        end
    end

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Bench for rob_multi_cdb: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rob_multi_cdb;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        disp_valid, disp_is_store, disp_is_br, disp_pred_taken, disp_done;
    logic [4:0]  disp_rd;
    logic [31:0] disp_pred_target, disp_fallthru, disp_value;
    logic [3:0]  disp_tag, q1_tag, q2_tag, cm_tag;
    logic        full, q1_ready, q2_ready;
    logic [31:0] q1_val, q2_val;
    logic [1:0]  cdb_valid, cdb_taken;
    logic [7:0]  cdb_tag;
    logic [63:0] cdb_value;
    logic        cm_valid, cm_store, flush;
    logic [4:0]  cm_rd;
    logic [31:0] cm_value, flush_pc;

    rob_multi_cdb dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_rd(disp_rd),
        .disp_is_store(disp_is_store), .disp_is_br(disp_is_br),
        .disp_pred_taken(disp_pred_taken), .disp_pred_target(disp_pred_target),
        .disp_fallthru(disp_fallthru), .disp_done(disp_done),
        .disp_value(disp_value), .disp_tag(disp_tag), .full(full),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .cdb_taken(cdb_taken),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_value(cm_value),
        .cm_tag(cm_tag), .cm_store(cm_store),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        bit          st, br, pt, done, at;
        logic [31:0] ptg, ft, val, atg;
    } ent_t;

    ent_t        q[$];
    int          m_head;
    bit          e_cv, e_st, e_fl;
    logic [4:0]  e_rd;
    logic [31:0] e_val, e_fpc;
    logic [3:0]  e_tag;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic [3:0] exp_tag();
        return 4'((m_head + q.size()) % 16);
    endfunction

    function automatic void qry(input logic [3:0] t, output bit r, output logic [31:0] v);
        int pos;
        pos = (int'(t) - m_head + 16) % 16;
        r = 0;
        v = 0;
        if (pos >= q.size())
            return;
        if (q[pos].done) begin
            r = 1;
            v = q[pos].val;
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (cdb_valid[k] && cdb_tag[k*4 +: 4] == t) begin
                r = 1;
                v = q[pos].br ? q[pos].val : cdb_value[k*32 +: 32];
                return;
            end
        end
    endfunction

    function automatic void model_edge();
        int   n;
        bit   com, mis;
        ent_t h, d;
        if (rst) begin
            q.delete();
            m_head = 0;
            e_cv = 0; e_rd = 0; e_val = 0; e_tag = 0;
            e_st = 0; e_fl = 0; e_fpc = 0;
            return;
        end
        if (!rdy) begin
            e_cv = 0;
            e_fl = 0;
            return;
        end
        n   = q.size();
        com = n > 0 && q[0].done;
        mis = 0;
        if (com) begin
            h     = q[0];
            mis   = h.br && (h.at != h.pt || (h.at && h.atg != h.ptg));
            e_rd  = h.st ? 5'd0 : h.rd;
            e_val = h.val;
            e_tag = 4'(m_head);
            e_st  = h.st;
            if (mis)
                e_fpc = h.at ? h.atg : h.ft;
        end
        e_cv = com;
        e_fl = mis;
        if (mis) begin
            q.delete();
            m_head = 0;
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (q[i].done)
                continue;
            for (int k = 0; k < 2; k++) begin
                if (cdb_valid[k] && int'(cdb_tag[k*4 +: 4]) == (m_head + i) % 16) begin
                    q[i].done = 1;
                    if (q[i].br) begin
                        q[i].at  = cdb_taken[k];
                        q[i].atg = cdb_value[k*32 +: 32];
                    end else begin
                        q[i].val = cdb_value[k*32 +: 32];
                    end
                    break;
                end
            end
        end
        if (com) begin
            void'(q.pop_front());
            m_head = (m_head + 1) % 16;
        end
        if (disp_valid && n < 16) begin
            d.rd = disp_rd; d.st = disp_is_store; d.br = disp_is_br;
            d.pt = disp_pred_taken; d.ptg = disp_pred_target;
            d.ft = disp_fallthru; d.val = disp_value; d.done = disp_done;
            d.at = disp_pred_taken; d.atg = disp_pred_target;
            q.push_back(d);
        end
    endfunction

    task automatic idle();
        disp_valid = 0; disp_rd = 0; disp_is_store = 0; disp_is_br = 0;
        disp_pred_taken = 0; disp_pred_target = 0; disp_fallthru = 0;
        disp_done = 0; disp_value = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_value = 0; cdb_taken = 0;
    endtask

    task automatic disp(input logic [4:0] rd, input bit done, input logic [31:0] val,
                        input bit br, input bit pt, input logic [31:0] ptg,
                        input logic [31:0] ft, input bit st);
        disp_valid = 1; disp_rd = rd; disp_done = done; disp_value = val;
        disp_is_br = br; disp_pred_taken = pt; disp_pred_target = ptg;
        disp_fallthru = ft; disp_is_store = st;
    endtask

    task automatic cdb(input int k, input logic [3:0] t, input logic [31:0] v, input bit tk);
        cdb_valid[k]         = 1;
        cdb_tag[k*4 +: 4]    = t;
        cdb_value[k*32 +: 32] = v;
        cdb_taken[k]         = tk;
    endtask

    task automatic cyc();
        bit          r;
        logic [31:0] v;
        #1;
        if (!rst) begin
            chk("disp_tag", disp_tag, exp_tag());
            chk("full", full, q.size() == 16);
            qry(q1_tag, r, v);
            chk("q1_ready", q1_ready, r);
            chk("q1_val", q1_val, v);
            qry(q2_tag, r, v);
            chk("q2_ready", q2_ready, r);
            chk("q2_val", q2_val, v);
        end
        model_edge();
        @(posedge clk);
        #1;
        chk("cm_valid", cm_valid, e_cv);
        chk("flush", flush, e_fl);
        chk("cm_rd", cm_rd, e_rd);
        chk("cm_value", cm_value, e_val);
        chk("cm_tag", cm_tag, e_tag);
        chk("cm_store", cm_store, e_st);
        chk("flush_pc", flush_pc, e_fpc);
        idle();
    endtask

    initial begin
        idle();
        rdy = 1; q1_tag = 0; q2_tag = 0; m_head = 0;
        rst = 1;
        cyc();
        rst = 0;
        chk("rst_cm_valid", cm_valid, 0);
        chk("rst_flush_pc", flush_pc, 0);

        // fill all 16 slots, then one more that must be ignored
        for (int i = 0; i < 16; i++) begin
            chk("fill_tag", disp_tag, i);
            disp(5'(i + 1), 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        chk("full_16", full, 1);
        disp(5'd9, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("tag_17th", disp_tag, 0);
        chk("full_17th", full, 1);

        cdb(0, 0, 32'hAA, 0);
        cyc();
        cyc();
        chk("c0_valid", cm_valid, 1);
        chk("c0_tag", cm_tag, 0);
        chk("c0_value", cm_value, 32'hAA);
        chk("c0_full", full, 0);

        // two channels on the same tag: channel 0 wins, visible via bypass
        cdb(0, 3, 32'h11, 0);
        cdb(1, 3, 32'h22, 0);
        q1_tag = 3;
        #1;
        chk("byp_ready", q1_ready, 1);
        chk("byp_val", q1_val, 32'h11);
        cyc();
        chk("st3_ready", q1_ready, 1);
        chk("st3_val", q1_val, 32'h11);

        rst = 1;
        cyc();
        rst = 0;
        disp(0, 0, 0, 1, 0, 32'h104, 32'h104, 0);
        cyc();
        disp(5'd5, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        cdb(0, 0, 32'h200, 1);
        cyc();
        disp(5'd6, 0, 0, 0, 0, 0, 0, 0);
        cyc();
        chk("mp_flush", flush, 1);
        chk("mp_pc", flush_pc, 32'h200);
        chk("mp_cm", cm_valid, 1);
        chk("mp_tag", disp_tag, 0);
        chk("mp_full", full, 0);
        q1_tag = 1;
        #1;
        chk("mp_q1", q1_ready, 0);

        disp(5'd1, 0, 32'h108, 1, 1, 32'h300, 32'h104, 0);
        cyc();
        cdb(0, 0, 32'h300, 1);
        cyc();
        cyc();
        chk("jr_flush", flush, 0);
        chk("jr_cm", cm_valid, 1);
        chk("jr_rd", cm_rd, 1);
        chk("jr_val", cm_value, 32'h108);

        disp(5'd2, 1, 32'h55, 0, 0, 0, 0, 0);
        cyc();
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("frz_cm", cm_valid, 0);
            chk("frz_tag", disp_tag, 2);
        end
        rdy = 1;
        cyc();
        chk("thaw_cm", cm_valid, 1);
        chk("thaw_tag", cm_tag, 1);
        chk("thaw_val", cm_value, 32'h55);

        for (int i = 0; i < 5; i++) begin
            disp(5'(i + 3), 0, 0, 0, 0, 0, 0, 0);
            cyc();
        end
        rst = 1;
        cyc();
        rst = 0;
        chk("mr_cm", cm_valid, 0);
        chk("mr_rd", cm_rd, 0);
        chk("mr_val", cm_value, 0);
        chk("mr_pc", flush_pc, 0);
        chk("mr_full", full, 0);
        chk("mr_tag", disp_tag, 0);

        // mixed traffic: wraps, stores, branches, freezes, flushes
        for (int c = 0; c < 400; c++) begin
            rdy = ($urandom % 8) != 0;
            if ($urandom % 2) begin
                bit br, st;
                br = ($urandom % 5) == 0;
                st = !br && ($urandom % 5) == 0;
                disp(5'($urandom), ($urandom % 3) == 0, $urandom, br,
                     1'($urandom), ($urandom % 2) ? 32'h40 : 32'h80,
                     32'h1000 + 32'($urandom % 64), st);
            end
            for (int k = 0; k < 2; k++)
                if ($urandom % 2)
                    cdb(k, 4'((m_head + $urandom_range(0, q.size())) % 16),
                        ($urandom % 3 == 0) ? $urandom : (($urandom % 2) ? 32'h40 : 32'h80),
                        1'($urandom));
            q1_tag = 4'($urandom);
            q2_tag = 4'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rob_multi_cdb.md
Name: rob_multi_cdb

Overview:
- Parametrised reorder buffer: circular queue of in-flight instructions between decode/dispatch and the register file/LSB.
- Accepts one dispatch and commits one entry per cycle, in order.
- Snoops NUM_CDB result buses and forwards operands to dispatch.
- Detects branch/jump mispredicts at commit and issues a full flush with a redirect PC.

Parameters:
- ENTRIES, 16, number of entries; power of two, at least 4.
- IDX_W, 4, log2(ENTRIES); tag width.
- XLEN, 32, data/PC width.
- NUM_CDB, 2, number of result broadcast channels (ALU, LSB, ...).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low freezes all state.
- disp_valid  in  1  dispatch request.
- disp_rd  in  5  destination register; 0 means no write.
- disp_is_store  in  1  store; no rd write.
- disp_is_br  in  1  branch/JAL/JALR entry (prediction checked at commit).
- disp_pred_taken  in  1  predicted direction.
- disp_pred_target  in  XLEN  predicted target.
- disp_fallthru  in  XLEN  PC+4 of the instruction.
- disp_done  in  1  entry is complete at dispatch (LUI/AUIPC/JAL/store).
- disp_value  in  XLEN  rd value when disp_done, or link value for jumps.
- disp_tag  out  IDX_W  tag the next accepted dispatch receives (= tail).
- full  out  1  count == ENTRIES.
- q1_tag, q2_tag  in  IDX_W  operand tags queried by dispatch.
- q1_ready, q2_ready  out  1  operand value available.
- q1_val, q2_val  out  XLEN  operand value.
- cdb_valid  in  NUM_CDB  per-channel valid.
- cdb_tag  in  NUM_CDB*IDX_W  packed tags; channel k occupies bits [k*IDX_W +: IDX_W].
- cdb_value  in  NUM_CDB*XLEN  packed results; for branch entries this is the actual target.
- cdb_taken  in  NUM_CDB  actual direction (branch entries only).
- cm_valid  out  1  commit pulse.
- cm_rd  out  5  destination register of the committed entry.
- cm_value  out  XLEN  value written to rd.
- cm_tag  out  IDX_W  committed tag, so the regfile clears its dependency only when tags match.
- cm_store  out  1  committed entry is a store (LSB releases it).
- flush  out  1  mispredict flush pulse.
- flush_pc  out  XLEN  redirect PC.

Behaviour:
- Reset (sync, clk rising edge with rst=1):
  - head=tail=0, count=0; all valid/ready bits cleared.
  - cm_valid=0, cm_rd=0, cm_value=0, cm_tag=0, cm_store=0, flush=0, flush_pc=0.
  - Reset overrides every other input, including mid-flush.
- rdy=0: no state change; registered outputs hold their values, except cm_valid and flush, which are forced 0 on that edge.
- Dispatch:
  - Accepted when disp_valid && !full && !flush_now.
  - Entry[tail] is written with all disp_* fields; ready=disp_done.
  - tail increments modulo ENTRIES (natural wrap 15->0).
  - full is computed from the current count only, so a full buffer blocks dispatch even if a commit happens in the same cycle.
- Count:
  - +1 on dispatch, -1 on commit; unchanged if both occur.
  - Width IDX_W+1.
- CDB writeback:
  - For each channel with cdb_valid whose tag hits a valid, not-ready entry: set ready and store the value.
  - Branch entries store cdb_value into the actual-target field and cdb_taken into the actual-direction field; the rd value stays as dispatched.
  - Several channels hitting the same tag in one cycle: lowest channel index wins.
  - Hits on invalid or already-ready entries are ignored.
- Operand query (combinational):
  - ready = entry ready, OR a same-cycle cdb_valid whose tag matches (CDB bypass; lowest channel wins).
  - val is the corresponding stored or bypassed value.
  - For an invalid entry, ready=0 and val=0.
- Commit:
  - Occurs when count!=0 && ready[head]; head increments and outputs are registered (1-cycle latency after head becomes ready).
  - cm_rd is forced to 0 for stores and for disp_rd=0.
  - Stores and branches still pulse cm_valid.
- Mispredict:
  - Condition at commit of a branch entry: actual_taken != pred_taken, OR (actual_taken && actual_target != pred_target).
  - flush_now = this condition; flush is registered and pulses in the same edge as cm_valid.
  - flush_pc = actual_taken ? actual_target : fallthru.
  - On that edge: all valid/ready cleared, head=tail=0, count=0; a dispatch in the same cycle is dropped; CDB writes in that cycle are discarded.
- Empty, or head not ready: cm_valid=0, flush=0.

Test Plan:
- Reset, then 16 dispatches with disp_done=0 -> disp_tag runs 0..15, full=1 after the 16th; a 17th request is ignored and tail stays 0.
- Fill, then CDB ch0 writes tag 0 with 0x0000_00AA -> next edge cm_valid=1, cm_tag=0, cm_value=0xAA; count=15, full=0.
- ch0 and ch1 both target tag 3 (0x11 / 0x22) in one cycle -> entry 3 holds 0x11; q1_tag=3 in that cycle returns q1_ready=1, q1_val=0x11 via bypass.
- Branch with pred_taken=0, fallthru=0x104; CDB taken=1, target 0x200 -> at commit flush=1, flush_pc=0x200; next cycle count=0 and disp_tag=0.
- JALR with pred_target 0x300, actual 0x300, taken=1 -> no flush; cm_rd gets the link value 0x108.
- rdy held low for 3 cycles with head ready -> no commit and state unchanged; commit occurs on the first edge after rdy=1. rst asserted mid-fill -> all outputs 0 and full=0.
